// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================
// Package  : fetch_pkg
// Brief    : Shared types and helpers for the instruction-fetch stage
// Revision : 1.0
// ============================================================
package fetch_pkg;

    // Queue entries carry a full 32-bit PC field; the fetch unit zero-extends narrower PCs
    localparam int unsigned c_pc_max_width = 32;
    localparam logic [31:0] c_nop_instr    = 32'h0000_0000;

    typedef struct packed {
        logic [c_pc_max_width-1:0] pc;
        logic [31:0]               instr;
    } fetch_entry_t;

    function automatic int unsigned qptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================
// Module   : fetch_queue
// Brief    : In-order circular buffer of fetched {pc, instr} entries
// Revision : 1.0
// ============================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  fetch_entry_t                  i_entry,
    input  logic                          i_pop,
    input  logic                          i_flush,
    output fetch_entry_t                  o_head,
    output logic                          o_valid,
    output logic [qptr_width(DEPTH):0]    o_count
);

    localparam int unsigned         c_pw      = qptr_width(DEPTH);
    localparam logic [c_pw-1:0]     c_ptr_one = 1;
    localparam logic [c_pw:0]       c_cnt_one = 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_pw:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================
// Module   : fetch_unit
// Brief    : Fetch PC, single-outstanding imem port, branch redirect/drop
// Revision : 1.0
// ============================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [PC_WIDTH-1:0]  PC_STEP     = 1,
    parameter int unsigned          QUEUE_DEPTH = 2,
    parameter logic [31:0]          NOP_INSTR   = c_nop_instr
) (
    input  logic                 CLK,
    input  logic                 RESET,
    output logic                 IMEM_REQ,
    output logic [PC_WIDTH-1:0]  IMEM_ADDR,
    input  logic                 IMEM_READY,
    input  logic                 IMEM_VALID,
    input  logic [31:0]          IMEM_DATA,
    input  logic                 PC_WRITE,
    input  logic                 BRANCH_TAKEN,
    input  logic [PC_WIDTH-1:0]  BRANCH_TARGET,
    output logic [31:0]          INSTR_OUT,
    output logic [PC_WIDTH-1:0]  COUNTER_OUT,
    output logic                 INSTR_VALID
);

    localparam int unsigned   c_pw    = qptr_width(QUEUE_DEPTH);
    localparam logic [c_pw:0] c_depth = QUEUE_DEPTH[c_pw:0];

    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PC_WIDTH-1:0] r_req_pc;
    logic                r_outstanding;
    logic                r_drop;

    logic [c_pw:0]       w_count;
    logic [c_pw:0]       w_occupancy;
    logic                w_queue_valid;
    fetch_entry_t        w_head;
    fetch_entry_t        w_entry;
    logic                w_pop;
    logic                w_resp;
    logic                w_push;
    logic                w_accept;

    assign w_pop  = w_queue_valid && PC_WRITE;
    assign w_resp = IMEM_VALID && r_outstanding;
    assign w_push = w_resp && !r_drop && !BRANCH_TAKEN;

    // Reserved slots: queued words plus the in-flight request, less what leaves this cycle
    assign w_occupancy = w_count + {{c_pw{1'b0}}, r_outstanding} - {{c_pw{1'b0}}, w_pop};

    assign IMEM_REQ  = !RESET && !BRANCH_TAKEN && (!r_outstanding || IMEM_VALID)
                       && (w_occupancy < c_depth);
    assign IMEM_ADDR = r_fetch_pc;
    assign w_accept  = IMEM_REQ && IMEM_READY;

    always_comb begin
        w_entry                   = '0;
        w_entry.pc[PC_WIDTH-1:0]  = r_req_pc;
        w_entry.instr             = IMEM_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else if (BRANCH_TAKEN) begin
            r_fetch_pc <= BRANCH_TARGET;
            if (r_outstanding && !IMEM_VALID) begin
                r_drop <= 1'b1;
            end else begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end
        end else begin
            if (w_resp) begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end
            if (w_accept) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + PC_STEP;
            end
        end
    end

    fetch_queue #(
        .DEPTH   (QUEUE_DEPTH)
    ) u_queue (
        .clk     (CLK),
        .rst     (RESET),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop && !BRANCH_TAKEN),
        .i_flush (BRANCH_TAKEN),
        .o_head  (w_head),
        .o_valid (w_queue_valid),
        .o_count (w_count)
    );

    assign INSTR_VALID = w_queue_valid;
    assign INSTR_OUT   = w_queue_valid ? w_head.instr : NOP_INSTR;
    assign COUNTER_OUT = w_queue_valid ? w_head.pc[PC_WIDTH-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================
// Module   : tb_fetch_unit
// Brief    : Directed scoreboard bench for fetch_unit with a variable-latency imem
// Revision : 1.0
// ============================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        RESET, PC_WRITE, BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_REQ, IMEM_READY, INSTR_VALID;
    logic        IMEM_VALID = 1'b0;
    logic [31:0] IMEM_DATA  = 32'h0;
    logic [31:0] IMEM_ADDR, INSTR_OUT, COUNTER_OUT;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] exp_q [$];

    // Memory model state
    logic        ready_en  = 1'b1;
    int          lat       = 1;
    logic        mem_free  = 1'b1;
    logic        busy      = 1'b0;
    int          cnt       = 0;
    logic [31:0] raddr     = 32'h0;
    logic        acc_nx    = 1'b0;
    logic [31:0] acc_addr  = 32'h0;
    int          acc_lat   = 1;

    assign IMEM_READY = ready_en && mem_free;

    always #5 clk = ~clk;

    fetch_unit dut (
        .CLK           (clk),
        .RESET         (RESET),
        .IMEM_REQ      (IMEM_REQ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_READY    (IMEM_READY),
        .IMEM_VALID    (IMEM_VALID),
        .IMEM_DATA     (IMEM_DATA),
        .PC_WRITE      (PC_WRITE),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .INSTR_OUT     (INSTR_OUT),
        .COUNTER_OUT   (COUNTER_OUT),
        .INSTR_VALID   (INSTR_VALID)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic to_cycle(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic exp_push(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + i);
    endtask

    // Responds with 0xA000_0000|addr, lat cycles after the accepting edge
    always begin
        @(negedge clk);
        if (IMEM_VALID) begin
            IMEM_VALID = 1'b0;
            busy       = 1'b0;
        end
        if (acc_nx) begin
            busy  = 1'b1;
            cnt   = acc_lat;
            raddr = acc_addr;
        end
        if (busy) begin
            cnt--;
            if (cnt <= 0) begin
                IMEM_VALID = 1'b1;
                IMEM_DATA  = 32'hA000_0000 | raddr;
            end
        end
        mem_free = !busy || IMEM_VALID;
        #3;
        acc_nx   = IMEM_REQ && IMEM_READY;
        acc_addr = IMEM_ADDR;
        acc_lat  = lat;
    end

    // Scoreboard monitor: every head the core consumes must match the next expected PC
    always begin
        logic [31:0] e;
        @(negedge clk);
        #2;
        if (!RESET && !BRANCH_TAKEN && PC_WRITE && INSTR_VALID) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_head: got pc %h expected none", COUNTER_OUT);
            end else begin
                e = exp_q.pop_front();
                chk("head_pc", COUNTER_OUT, e);
                chk("head_instr", INSTR_OUT, 32'hA000_0000 | e);
            end
        end
    end

    initial begin
        RESET = 1'b1; PC_WRITE = 1'b1; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req",   {31'b0, IMEM_REQ},    32'h0);
        chk("rst_valid", {31'b0, INSTR_VALID}, 32'h0);
        chk("rst_instr", INSTR_OUT,            32'h0);
        chk("rst_pc",    COUNTER_OUT,          32'h0);

        @(negedge clk);
        cyc = 1;
        RESET = 1'b0;
        exp_push(32'h0, 12);
        #1;
        chk("c1_req",  {31'b0, IMEM_REQ}, 32'h1);
        chk("c1_addr", IMEM_ADDR,         32'h0);
        to_cycle(2); #1;
        chk("c2_valid", {31'b0, INSTR_VALID}, 32'h0);

        // Hold head pc=5 for three cycles
        to_cycle(8); PC_WRITE = 1'b0; #1;
        chk("hold_req_c8", {31'b0, IMEM_REQ}, 32'h0);
        to_cycle(9); #1;
        chk("hold_pc_c9",  COUNTER_OUT,       32'h5);
        chk("hold_req_c9", {31'b0, IMEM_REQ}, 32'h0);
        to_cycle(10); #1;
        chk("hold_pc_c10",    COUNTER_OUT,       32'h5);
        chk("hold_instr_c10", INSTR_OUT,         32'hA000_0005);
        chk("hold_req_c10",   {31'b0, IMEM_REQ}, 32'h0);
        to_cycle(11); PC_WRITE = 1'b1; #1;
        chk("resume_req",  {31'b0, IMEM_REQ}, 32'h1);
        chk("resume_addr", IMEM_ADDR,         32'h7);

        // Memory stalls for four cycles
        to_cycle(12); ready_en = 1'b0;
        for (int k = 12; k <= 15; k++) begin
            to_cycle(k); #1;
            chk("stall_req",  {31'b0, IMEM_REQ}, 32'h1);
            chk("stall_addr", IMEM_ADDR,         32'h8);
            if (k == 14) begin
                chk("drain_valid", {31'b0, INSTR_VALID}, 32'h0);
                chk("drain_instr", INSTR_OUT,            32'h0);
                chk("drain_pc",    COUNTER_OUT,          32'h0);
            end
        end
        to_cycle(16); ready_en = 1'b1;

        // Branch while a slow request (pc=12) is outstanding
        to_cycle(20); lat = 3;
        to_cycle(22); BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40; #1;
        chk("br1_req", {31'b0, IMEM_REQ}, 32'h0);
        to_cycle(23); BRANCH_TAKEN = 1'b0; lat = 1; exp_push(32'h40, 2); #1;
        chk("br1_tgt_req",  {31'b0, IMEM_REQ}, 32'h1);
        chk("br1_tgt_addr", IMEM_ADDR,         32'h40);
        to_cycle(24); #1;
        chk("br1_dropped", {31'b0, INSTR_VALID}, 32'h0);

        // Branch in the same cycle as a response
        to_cycle(27); BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h80; #1;
        chk("br2_req", {31'b0, IMEM_REQ}, 32'h0);
        to_cycle(28); BRANCH_TAKEN = 1'b0; exp_push(32'h80, 2); #1;
        chk("br2_empty",    {31'b0, INSTR_VALID}, 32'h0);
        chk("br2_tgt_req",  {31'b0, IMEM_REQ},    32'h1);
        chk("br2_tgt_addr", IMEM_ADDR,            32'h80);

        // Reset with a queued word and a slow request in flight
        to_cycle(31); lat = 3;
        to_cycle(32); PC_WRITE = 1'b0;
        to_cycle(33); RESET = 1'b1; lat = 1; #1;
        chk("rst2_req", {31'b0, IMEM_REQ}, 32'h0);
        to_cycle(34); RESET = 1'b0; PC_WRITE = 1'b1; exp_push(32'h0, 4); #1;
        chk("rst2_valid", {31'b0, INSTR_VALID}, 32'h0);
        chk("rst2_instr", INSTR_OUT,            32'h0);
        chk("rst2_pc",    COUNTER_OUT,          32'h0);
        chk("rst2_req",   {31'b0, IMEM_REQ},    32'h1);
        chk("rst2_addr",  IMEM_ADDR,            32'h0);
        to_cycle(35); #1;
        chk("late_resp_ignored", {31'b0, INSTR_VALID}, 32'h0);
        to_cycle(40); PC_WRITE = 1'b0;
        to_cycle(43); #1;
        chk("scoreboard_left", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
